// File: rtl/alu_reg_if.sv
// alu_reg_if: operand/result bundle for the registered ALU.
//   SrcA, SrcB   : operands (WIDTH bits)
//   ALUControl   : 00 ADD, 01 SUB, 10 AND, 11 ORR
//   ALUResult    : registered result (WIDTH bits)
//   Zero/Negative/Overflow/Carry : registered condition flags
//   in_valid/out_valid : present only when ALU_VALID_EN is defined
// Modports: master drives operands and reads results; slave is the ALU side.
interface alu_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Negative;
  logic             Overflow;
  logic             Carry;
`ifdef ALU_VALID_EN
  logic             in_valid;
  logic             out_valid;
`endif

  modport master (
    output SrcA, SrcB, ALUControl,
`ifdef ALU_VALID_EN
    output in_valid,
    input  out_valid,
`endif
    input  ALUResult, Zero, Negative, Overflow, Carry
  );

  modport slave (
    input  SrcA, SrcB, ALUControl,
`ifdef ALU_VALID_EN
    input  in_valid,
    output out_valid,
`endif
    output ALUResult, Zero, Negative, Overflow, Carry
  );
endinterface

// File: rtl/alu_reg.sv
// alu_reg: registered 32-bit datapath ALU (ADD/SUB/AND/ORR) with N/Z/C/V flags.
// One clock of latency: operands sampled on a rising clk edge, result and
// flags valid after that edge and held until the next.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset (ALUResult=0, Zero=1, others 0)
//   bus   : alu_reg_if.slave (SrcA, SrcB, ALUControl in; ALUResult and flags out)
// Optional feature macro ALU_VALID_EN: adds bus.in_valid / bus.out_valid;
// registers then load only when in_valid=1, and out_valid is in_valid
// delayed one cycle.
module alu_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_reg_if.slave bus
);

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             n_d;
  logic             z_d;
  logic             c_d;
  logic             v_d;

  // One shared adder: SUB inverts B and uses ALUControl[0] as carry-in.
  always_comb begin
    b_op  = bus.ALUControl[0] ? ~bus.SrcB : bus.SrcB;
    sum   = {1'b0, bus.SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, bus.ALUControl[0]};
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (bus.ALUControl)
      2'b00, 2'b01: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        // Operand signs (after B inversion) agree, and sum sign differs.
        v_d   = ~(bus.ALUControl[0] ^ bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1])
                & (sum[WIDTH-1] ^ bus.SrcA[WIDTH-1]);
      end
      2'b10:   res_d = bus.SrcA & bus.SrcB;
      default: res_d = bus.SrcA | bus.SrcB;
    endcase
    n_d = res_d[WIDTH-1];
    z_d = (res_d == '0);
  end

  logic load;
`ifdef ALU_VALID_EN
  assign load = bus.in_valid;

  always_ff @(posedge clk) begin
    if (reset) bus.out_valid <= 1'b0;
    else       bus.out_valid <= bus.in_valid;
  end
`else
  assign load = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ALUResult <= '0;
      bus.Zero      <= 1'b1;
      bus.Negative  <= 1'b0;
      bus.Overflow  <= 1'b0;
      bus.Carry     <= 1'b0;
    end else if (load) begin
      bus.ALUResult <= res_d;
      bus.Zero      <= z_d;
      bus.Negative  <= n_d;
      bus.Overflow  <= v_d;
      bus.Carry     <= c_d;
    end
  end

endmodule

// File: tb/tb_alu_reg.sv
// tb_alu_reg: directed self-checking bench for alu_reg (WIDTH=32).
// Flags are compared as a packed {N,Z,C,V} nibble.
module tb_alu_reg;

  logic clk;
  logic reset;
  int unsigned passed;
  int unsigned total;

  alu_reg_if #(.WIDTH(32)) bus ();

  alu_reg #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive one operation, let one rising edge sample it, then check outputs.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [1:0] ctl, input logic [31:0] exp_res, input logic [3:0] exp_nzcv);
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.ALUControl = ctl;
    @(posedge clk);
    #1;
    chk({tag, "_res"}, bus.ALUResult, exp_res);
    chk({tag, "_nzcv"}, {28'd0, bus.Negative, bus.Zero, bus.Carry, bus.Overflow}, {28'd0, exp_nzcv});
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    bus.SrcA       = 32'h1234_5678;
    bus.SrcB       = 32'h1111_1111;
    bus.ALUControl = 2'b00;
`ifdef ALU_VALID_EN
    bus.in_valid = 1'b1;
`endif

    // Reset held two cycles; outputs at reset values despite live operands.
    @(posedge clk); #1;
    chk("rst1_res", bus.ALUResult, 32'h0);
    chk("rst1_nzcv", {28'd0, bus.Negative, bus.Zero, bus.Carry, bus.Overflow}, 32'h4);
    @(posedge clk); #1;
    chk("rst2_res", bus.ALUResult, 32'h0);
    chk("rst2_nzcv", {28'd0, bus.Negative, bus.Zero, bus.Carry, bus.Overflow}, 32'h4);
`ifdef ALU_VALID_EN
    chk("rst_ov", {31'd0, bus.out_valid}, 32'h0);
`endif
    reset = 1'b0;

    op("add_4_5",   32'd4, 32'd5, 2'b00, 32'd9,          4'b0000);
    op("sub_4_5",   32'd4, 32'd5, 2'b01, 32'hFFFF_FFFF,  4'b1000);
    op("and_4_5",   32'd4, 32'd5, 2'b10, 32'd4,          4'b0000);
    op("orr_4_5",   32'd4, 32'd5, 2'b11, 32'd5,          4'b0000);
    op("add_ovf",   32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 4'b1001);
    op("add_wrap",  32'hFFFF_FFFF, 32'd1, 2'b00, 32'h0,         4'b0110);
    // Logic op right after a carry: C must drop to 0.
    op("and_neg",   32'hFFFF_0000, 32'hF0F0_F0F0, 2'b10, 32'hF0F0_0000, 4'b1000);
    op("sub_ovf",   32'h8000_0000, 32'd1, 2'b01, 32'h7FFF_FFFF, 4'b0011);
    op("sub_7_7",   32'd7, 32'd7, 2'b01, 32'h0, 4'b0110);
    op("sub_0_0",   32'd0, 32'd0, 2'b01, 32'h0, 4'b0110);
    op("sub_5_4",   32'd5, 32'd4, 2'b01, 32'd1, 4'b0010);
    op("orr_zero",  32'd0, 32'd0, 2'b11, 32'h0, 4'b0100);
    op("add_negneg",32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0, 4'b0111);
    op("orr_msb",   32'h8000_0000, 32'h0000_0001, 2'b11, 32'h8000_0001, 4'b1000);

    // Changing inputs between edges must not disturb the registered output.
    bus.SrcA = 32'd100; bus.SrcB = 32'd1; bus.ALUControl = 2'b00;
    #3;
    chk("hold_res", bus.ALUResult, 32'h8000_0001);
    @(posedge clk); #1;
    chk("next_res", bus.ALUResult, 32'd101);

    // Reset mid-stream discards the in-flight operation.
    reset = 1'b1;
    op("mid_rst",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0, 4'b0100);
    reset = 1'b0;
    op("post_rst",  32'd10, 32'd3, 2'b01, 32'd7, 4'b0010);

`ifdef ALU_VALID_EN
    chk("ov_hi", {31'd0, bus.out_valid}, 32'h1);
    bus.in_valid = 1'b0;
    op("hold_inv",  32'd1, 32'd1, 2'b00, 32'd7, 4'b0010);
    chk("ov_lo", {31'd0, bus.out_valid}, 32'h0);
    bus.in_valid = 1'b1;
    op("resume",    32'd1, 32'd1, 2'b00, 32'd2, 4'b0000);
    chk("ov_back", {31'd0, bus.out_valid}, 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
